// File: rtl/bs_arbtr_rr_bp_if.sv
// Packet bus bundle between the arbiter and the devices: FIFO heads,
// back-pressure, pop/push strobes, shared push data and status.
interface bs_arbtr_rr_bp_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16,
    parameter int cnt_w   = 16
);
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         full;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [pckg_sz-1:0]       D_push;
    logic                     busy;
    logic [3:0]               grant_id;
    logic [cnt_w-1:0]         drop_cnt;

    modport master (
        input  pndng, D_pop, full,
        output pop, push, D_push, busy, grant_id, drop_cnt
    );

    modport slave (
        output pndng, D_pop, full,
        input  pop, push, D_push, busy, grant_id, drop_cnt
    );
endinterface

// File: rtl/bs_arbtr_rr_bp.sv
// Packet bus arbiter: grants one device at a time (round-robin or fixed
// priority), pops its packet, decodes the destination and pushes it to one
// device or, on broadcast, to every other device, honouring back-pressure.
//
// state   | meaning
// IDLE    | waiting for any pndng, selects the grant
// POP     | pop strobe to the granted device, capture its FIFO head
// ROUTE   | decode destination, drop invalid packets or load the push bus
// DELIVER | wait until every target has room, then push once
module bs_arbtr_rr_bp #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         arb_mode  = 0,
    parameter int         cnt_w     = 16
) (
    input logic              clk,
    input logic              reset,
    bs_arbtr_rr_bp_if.master bus
);
    typedef enum logic [1:0] {IDLE, POP, ROUTE, DELIVER} state_t;

    state_t             r_state;
    logic [3:0]         r_g;
    logic [3:0]         r_last;
    logic [3:0]         r_grant;
    logic [drvrs-1:0]   r_pop;
    logic [drvrs-1:0]   r_tgt;
    logic [pckg_sz-1:0] r_pkt;
    logic [pckg_sz-1:0] r_dpush;
    logic [cnt_w-1:0]   r_drop;

    logic [3:0]         w_sel;
    logic [drvrs-1:0]   w_hi;
    logic [drvrs-1:0]   w_cand;
    logic [drvrs-1:0]   w_tgt;
    logic [pckg_sz-1:0] w_head;
    logic [7:0]         w_dest;
    logic               w_drop;

    function automatic logic [3:0] lowest_set(input logic [drvrs-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = drvrs - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Grant pick: round-robin prefers requesters above the last grant and
    // wraps to the lowest index; fixed priority always takes the lowest.
    always_comb begin
        w_hi   = bus.pndng & ~((drvrs'(2) << r_last) - drvrs'(1));
        w_cand = bus.pndng;
        if (arb_mode == 0 && w_hi != '0) w_cand = w_hi;
        w_sel = lowest_set(w_cand);
    end

    // FIFO head of the granted device.
    always_comb begin
        w_head = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (r_g == 4'(i)) w_head = bus.D_pop[i*pckg_sz +: pckg_sz];
        end
    end

    // Destination decode of the captured packet; broadcast excludes the source.
    always_comb begin
        w_dest = r_pkt[pckg_sz-1 -: 8];
        w_tgt  = '0;
        w_drop = 1'b0;
        if (w_dest == broadcast) begin
            w_tgt = ~(drvrs'(1) << r_g);
        end else if (int'(w_dest) < drvrs && w_dest != 8'(r_g)) begin
            w_tgt = drvrs'(1) << w_dest;
        end else begin
            w_drop = 1'b1;
        end
    end

    // Main sequencer: grant, pop, route, deliver.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_last  <= 4'(drvrs - 1);
            r_grant <= '0;
            r_pop   <= '0;
            r_tgt   <= '0;
            r_pkt   <= '0;
            r_dpush <= '0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.pndng != '0) begin
                        r_g     <= w_sel;
                        r_pop   <= drvrs'(1) << w_sel;
                        r_state <= POP;
                    end
                end
                POP: begin
                    r_pop   <= '0;
                    r_pkt   <= w_head;
                    r_grant <= r_g;
                    r_state <= ROUTE;
                end
                ROUTE: begin
                    if (w_drop) begin
                        if (r_drop != '1) r_drop <= r_drop + cnt_w'(1);
                        r_last  <= r_g;
                        r_state <= IDLE;
                    end else begin
                        r_tgt   <= w_tgt;
                        r_dpush <= r_pkt;
                        r_state <= DELIVER;
                    end
                end
                DELIVER: begin
                    if ((r_tgt & bus.full) == '0) begin
                        r_last  <= r_g;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Push reacts to full in the same cycle so delivery fires as soon as all targets free up.
    assign bus.push     = (r_state == DELIVER && (r_tgt & bus.full) == '0) ? r_tgt : '0;
    assign bus.pop      = r_pop;
    assign bus.D_push   = r_dpush;
    assign bus.busy     = (r_state != IDLE);
    assign bus.grant_id = r_grant;
    assign bus.drop_cnt = r_drop;
endmodule

// File: tb/tb_bs_arbtr_rr_bp.sv
// Bench for bs_arbtr_rr_bp: a round-robin instance (16-bit drop counter) and a
// fixed-priority instance (3-bit drop counter) share the same stimulus; both
// are compared every cycle against a transaction-level model.
module tb_bs_arbtr_rr_bp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_pndng;
    logic [63:0] s_dpop;
    logic [3:0]  s_full;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bs_arbtr_rr_bp_if #(.drvrs(4), .pckg_sz(16), .cnt_w(16)) if0 ();
    bs_arbtr_rr_bp_if #(.drvrs(4), .pckg_sz(16), .cnt_w(3))  if1 ();

    assign if0.pndng = s_pndng;
    assign if0.D_pop = s_dpop;
    assign if0.full  = s_full;
    assign if1.pndng = s_pndng;
    assign if1.D_pop = s_dpop;
    assign if1.full  = s_full;

    bs_arbtr_rr_bp #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .arb_mode(0), .cnt_w(16))
        u_rr (.clk(clk), .reset(rst_n), .bus(if0));
    bs_arbtr_rr_bp #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .arb_mode(1), .cnt_w(3))
        u_fp (.clk(clk), .reset(rst_n), .bus(if1));

    // Model: one in-flight transaction per instance; age counts cycles since grant
    // (1 = pop cycle, 2 = route cycle, 3 = delivering).
    int          m_act[2];
    int          m_age[2];
    int          m_g[2];
    int          m_last[2];
    int          m_grant[2];
    int          m_drop[2];
    bit          m_isd[2];
    logic [15:0] m_pkt[2];
    logic [15:0] m_dpush[2];
    logic [3:0]  m_tgt[2];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int pick(input int k, input int last, input logic [3:0] p);
        int r;
        int d;
        r = -1;
        for (int s = 1; s <= 4; s++) begin
            d = (k == 1) ? s - 1 : (last + s) % 4;
            if (r < 0 && p[d]) r = d;
        end
        return r;
    endfunction

    task automatic model_step(input int k);
        logic [15:0] pk;
        int          dest;
        int          maxc;
        maxc = (k == 0) ? 65535 : 7;
        if (!rst_n) begin
            m_act[k] = 0; m_age[k] = 0; m_g[k] = 0; m_last[k] = 3;
            m_grant[k] = 0; m_drop[k] = 0; m_dpush[k] = '0; m_tgt[k] = '0;
        end else if (m_act[k] == 0) begin
            if (s_pndng != 0) begin
                m_g[k] = pick(k, m_last[k], s_pndng);
                m_act[k] = 1;
                m_age[k] = 1;
            end
        end else if (m_age[k] == 1) begin
            pk = 16'(s_dpop >> (m_g[k] * 16));
            m_pkt[k] = pk;
            m_grant[k] = m_g[k];
            dest = int'(pk[15:8]);
            m_isd[k] = 1'b0;
            if (dest == 255) m_tgt[k] = 4'hF & ~(4'b0001 << m_g[k]);
            else if (dest < 4 && dest != m_g[k]) m_tgt[k] = 4'b0001 << dest;
            else m_isd[k] = 1'b1;
            m_age[k] = 2;
        end else if (m_age[k] == 2) begin
            if (m_isd[k]) begin
                if (m_drop[k] < maxc) m_drop[k] = m_drop[k] + 1;
                m_last[k] = m_g[k];
                m_act[k] = 0;
            end else begin
                m_dpush[k] = m_pkt[k];
                m_age[k] = 3;
            end
        end else begin
            if ((m_tgt[k] & s_full) == 4'b0) begin
                m_last[k] = m_g[k];
                m_act[k] = 0;
            end
        end
    endtask

    task automatic cmp_one(input int k, input logic [31:0] pop, input logic [31:0] push,
                           input logic [31:0] dp, input logic [31:0] busy,
                           input logic [31:0] gid, input logic [31:0] drop);
        logic [31:0] e_pop;
        logic [31:0] e_push;
        e_pop  = (m_act[k] != 0 && m_age[k] == 1) ? (32'd1 << m_g[k]) : 32'd0;
        e_push = (m_act[k] != 0 && m_age[k] == 3 && (m_tgt[k] & s_full) == 4'b0) ? 32'(m_tgt[k]) : 32'd0;
        chk($sformatf("u%0d.pop", k), pop, e_pop);
        chk($sformatf("u%0d.push", k), push, e_push);
        chk($sformatf("u%0d.D_push", k), dp, 32'(m_dpush[k]));
        chk($sformatf("u%0d.busy", k), busy, 32'(m_act[k]));
        chk($sformatf("u%0d.grant_id", k), gid, 32'(m_grant[k]));
        chk($sformatf("u%0d.drop_cnt", k), drop, 32'(m_drop[k]));
    endtask

    task automatic tick(input logic r, input logic [3:0] p, input logic [63:0] d, input logic [3:0] f);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        rst_n = r; s_pndng = p; s_dpop = d; s_full = f;
        #1;
        cmp_one(0, 32'(if0.pop), 32'(if0.push), 32'(if0.D_push), 32'(if0.busy), 32'(if0.grant_id), 32'(if0.drop_cnt));
        cmp_one(1, 32'(if1.pop), 32'(if1.push), 32'(if1.D_push), 32'(if1.busy), 32'(if1.grant_id), 32'(if1.drop_cnt));
    endtask

    function automatic logic [63:0] pkt_vec(input int dev, input logic [15:0] pkt);
        return 64'(pkt) << (dev * 16);
    endfunction

    task automatic do_reset();
        tick(1'b0, 4'h0, 64'h0, 4'h0);
        tick(1'b0, 4'h0, 64'h0, 4'h0);
    endtask

    task automatic run_pkt(input int dev, input logic [15:0] pkt, input logic [3:0] fh,
                           input int nh, input logic [3:0] exp_push);
        logic [63:0] d;
        d = pkt_vec(dev, pkt);
        tick(1'b1, 4'(1 << dev), d, 4'h0);
        tick(1'b1, 4'h0, d, 4'h0);
        chk("pkt.pop_strobe", 32'(if0.pop), 32'(1 << dev));
        tick(1'b1, 4'h0, d, fh);
        for (int i = 0; i < nh; i++) begin
            tick(1'b1, 4'h0, d, fh);
            chk("bp.push_held", 32'(if0.push), 32'd0);
            chk("bp.dpush_stable", 32'(if0.D_push), 32'(pkt));
        end
        tick(1'b1, 4'h0, d, 4'h0);
        chk("pkt.push_rr", 32'(if0.push), 32'(exp_push));
        chk("pkt.push_fp", 32'(if1.push), 32'(exp_push));
        chk("pkt.dpush", 32'(if0.D_push), 32'(pkt));
        tick(1'b1, 4'h0, 64'h0, 4'h0);
        chk("pkt.busy_after", 32'(if0.busy), 32'd0);
    endtask

    task automatic run_drop(input int dev, input logic [15:0] pkt, input int exp0, input int exp1);
        logic [63:0] d;
        d = pkt_vec(dev, pkt);
        tick(1'b1, 4'(1 << dev), d, 4'h0);
        tick(1'b1, 4'h0, d, 4'h0);
        tick(1'b1, 4'h0, d, 4'h0);
        tick(1'b1, 4'h0, d, 4'h0);
        chk("drop.push", 32'(if0.push), 32'd0);
        chk("drop.busy", 32'(if0.busy), 32'd0);
        chk("drop.cnt_rr", 32'(if0.drop_cnt), 32'(exp0));
        chk("drop.cnt_fp", 32'(if1.drop_cnt), 32'(exp1));
    endtask

    initial begin
        logic [63:0] d_all;
        logic [3:0]  exp_seq[6];
        int          t_pop[$];
        logic [3:0]  v_pop[$];
        int          n_fp;
        logic [3:0]  rp;
        logic [3:0]  rf;
        logic [63:0] rd;
        int          sel;
        logic [7:0]  dst;

        d_all   = {16'h0003, 16'h0302, 16'h0201, 16'h0100};
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst_n = 1'b0; s_pndng = '0; s_dpop = '0; s_full = '0;

        do_reset();
        chk("reset.busy", 32'(if0.busy), 32'd0);
        chk("reset.pop", 32'(if0.pop), 32'd0);
        chk("reset.D_push", 32'(if0.D_push), 32'd0);
        chk("reset.drop_cnt", 32'(if0.drop_cnt), 32'd0);
        tick(1'b1, 4'h0, 64'h0, 4'h0);

        run_pkt(0, 16'h02AB, 4'h0, 0, 4'b0100);
        run_pkt(1, 16'hFF11, 4'h0, 0, 4'b1101);
        run_pkt(3, 16'h0255, 4'b0100, 5, 4'b0100);
        run_pkt(1, 16'hFF11, 4'b0001, 4, 4'b1101);

        do_reset();
        n_fp = 0;
        for (int t = 0; t < 24; t++) begin
            tick(1'b1, 4'hF, d_all, 4'h0);
            if (if0.pop != 4'h0) begin
                t_pop.push_back(t);
                v_pop.push_back(if0.pop);
            end
            if (if1.pop != 4'h0) begin
                n_fp++;
                chk("fp.grant_dev0", 32'(if1.pop), 32'd1);
            end
        end
        chk("rr.grant_count", 32'(t_pop.size()), 32'd6);
        chk("fp.grant_count", 32'(n_fp), 32'd6);
        for (int i = 0; i < 6 && i < v_pop.size(); i++) begin
            chk($sformatf("rr.order%0d", i), 32'(v_pop[i]), 32'(exp_seq[i]));
            if (i > 0) chk($sformatf("rr.spacing%0d", i), 32'(t_pop[i] - t_pop[i-1]), 32'd4);
        end
        tick(1'b1, 4'h0, d_all, 4'h0);
        tick(1'b1, 4'h0, d_all, 4'h0);
        tick(1'b1, 4'h0, d_all, 4'h0);

        do_reset();
        run_drop(0, 16'h07CC, 1, 1);
        run_drop(0, 16'h00CC, 2, 2);
        for (int i = 3; i <= 8; i++) run_drop(i % 4, {8'(9 + i), 8'hCC}, i, (i < 7) ? i : 7);

        run_pkt(2, 16'h0155, 4'h0, 0, 4'b0010);
        tick(1'b1, 4'b1000, pkt_vec(3, 16'h0255), 4'b0100);
        tick(1'b1, 4'h0, pkt_vec(3, 16'h0255), 4'b0100);
        tick(1'b1, 4'h0, pkt_vec(3, 16'h0255), 4'b0100);
        tick(1'b1, 4'h0, pkt_vec(3, 16'h0255), 4'b0100);
        chk("rst.in_deliver", 32'(if0.busy), 32'd1);
        tick(1'b0, 4'h0, pkt_vec(3, 16'h0255), 4'b0100);
        tick(1'b1, 4'hF, d_all, 4'h0);
        chk("rst.push", 32'(if0.push), 32'd0);
        chk("rst.busy", 32'(if0.busy), 32'd0);
        chk("rst.drop_rr", 32'(if0.drop_cnt), 32'd0);
        chk("rst.drop_fp", 32'(if1.drop_cnt), 32'd0);
        tick(1'b1, 4'h0, d_all, 4'h0);
        chk("rst.first_grant", 32'(if0.pop), 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'h0, d_all, 4'h0);

        for (int n = 0; n < 3000; n++) begin
            rp = 4'($urandom_range(0, 15));
            rf = '0;
            rd = '0;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rf[b] = 1'b1;
                sel = int'($urandom_range(0, 7));
                if (sel < 4) dst = 8'(sel);
                else if (sel < 6) dst = 8'hFF;
                else dst = 8'($urandom_range(0, 255));
                rd[b*16 +: 16] = {dst, 8'($urandom_range(0, 255))};
            end
            tick(($urandom_range(0, 299) != 0), rp, rd, rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bs_arbtr_rr_bp.md
Name: bs_arbtr_rr_bp

Overview:
Next-generation bus generator/arbiter for the multi-device packet bus. Each device exposes a first-word-fall-through FIFO head (pndng/D_pop/pop). The block grants one device at a time using either round-robin or fixed-priority arbitration, pops and decodes that device's packet, and delivers it on the shared D_push bus to one destination or, on broadcast, to all other devices. New in this generation: destination back-pressure through per-device full inputs, a selectable arbitration mode, and drop accounting for invalid addresses.

Parameters:
drvrs, 4, number of devices on the bus (2..16)
pckg_sz, 16, packet width in bits; the destination field is bits [pckg_sz-1 -: 8]
broadcast, 8'hFF, destination value meaning all devices except the source
arb_mode, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
cnt_w, 16, width of the drop counter

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-low reset
pndng  in  drvrs  device i FIFO non-empty
D_pop  in  drvrs*pckg_sz  FIFO head of device i at slice [i*pckg_sz +: pckg_sz]
full  in  drvrs  device i cannot accept a push this cycle
pop  out  drvrs  one-hot, 1-cycle pop strobe to the granted device
push  out  drvrs  push strobe(s) to the destination device(s)
D_push  out  pckg_sz  packet being delivered, common to all devices
busy  out  1  high whenever state != IDLE
grant_id  out  4  index of the current or last granted device
drop_cnt  out  cnt_w  saturating count of dropped packets

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; pop=0, push=0, D_pop-capture register=0, D_push=0, busy=0, grant_id=0, drop_cnt=0.
  - Round-robin pointer last=drvrs-1, so device 0 has first priority.
- FSM states: IDLE, POP, ROUTE, DELIVER.
- IDLE:
  - If pndng != 0, select grant g and go to POP.
  - Round-robin: g is the first set pndng bit scanning from (last+1) mod drvrs upward with wrap-around.
  - Fixed priority: g is the lowest set index.
- POP (exactly 1 cycle):
  - pop[g]=1; pkt <= D_pop[g]; grant_id <= g; go to ROUTE.
- ROUTE (1 cycle): dest = pkt[pckg_sz-1 -: 8].
  - dest==broadcast: tgt = all ones with bit g cleared.
  - dest<drvrs and dest!=g: tgt = one-hot(dest).
  - Otherwise (out of range or self-addressed): drop the packet, drop_cnt++ (saturating at all ones), last<=g, go to IDLE.
  - For a valid dest, D_push <= pkt and go to DELIVER.
- DELIVER:
  - push = tgt when (tgt & full)==0; otherwise push=0 and remain in DELIVER, holding D_push stable indefinitely.
  - Delivery is all-or-nothing: a broadcast waits until every target is not full.
  - On the push cycle: last<=g, go to IDLE.
- Latency:
  - pndng seen in IDLE at cycle N: pop at N+1, push at N+3 at the earliest.
  - Minimum 4 cycles per packet; a new grant is evaluated in the cycle after a push.
- pndng dropping while in POP/ROUTE/DELIVER has no effect; the packet is already captured.
- full changing mid-DELIVER: evaluated every cycle, so push fires in the first cycle where (tgt & full)==0.
- Reset mid-operation: the in-flight packet is discarded with no replay; push and pop are 0 from the next cycle.
- pop and push are never asserted in the same cycle.
- pop is always one-hot or zero.

Test Plan:
1. Unicast. drvrs=4, reset released; device 0 pndng=1, D_pop=16'h02AB.
   -> pop=4'b0001 at N+1; push=4'b0100 with D_push=16'h02AB at N+3; busy low at N+4.
2. Broadcast from device 1, D_pop=16'hFF11.
   -> push=4'b1101 for one cycle, D_push=16'hFF11; push[1]=0.
3. Round-robin fairness. arb_mode=0, all four pndng held high with valid packets.
   -> grant order 0,1,2,3,0,1; each grant separated by 4 cycles.
   Same stimulus with arb_mode=1.
   -> every grant is device 0.
4. Back-pressure. Device 3 sends 16'h0255 with full[2]=1 for 5 cycles after reaching DELIVER.
   -> push stays 0 and D_push holds 16'h0255; push[2]=1 in the cycle full[2] falls.
   Broadcast with only full[0]=1.
   -> no partial push; the broadcast waits for full[0]=0.
5. Drops. Device 0 sends 16'h07CC (dest out of range), then 16'h00CC (self-addressed).
   -> no push for either; drop_cnt=2. Force drop_cnt=16'hFFFF and drop again -> drop_cnt stays 16'hFFFF.
6. Reset. Drive reset=0 while in DELIVER under back-pressure.
   -> next cycle push=0, busy=0, drop_cnt=0, state IDLE; after release, the first grant goes to device 0.
